// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
// Provides the channel-index width helper and the arbitration mode encodings.
package stream_mux_pkg;

   // Width of a channel index; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter with fixed-priority and round-robin modes.
// Ports:
//   req       - per-channel request vector
//   ptr       - round-robin start index (ignored in fixed mode)
//   mode      - MODE_FIXED: lowest index wins; MODE_RR: first request at/after ptr
//   grant     - one-hot grant, zero when no request
//   grant_idx - index of the granted channel, zero when no request
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = sel_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             mode,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] req_msk;
   int             base;
   int             hit;

   // Requests are laid out twice so the search starting at ptr can run past
   // the top channel and continue at channel 0 without a modulo operation.
   // Bits below the start index are masked off; the lowest surviving bit wins.
   always_comb begin
      base    = (mode == MODE_RR) ? int'(ptr) : 0;
      req_dbl = {req, req};
      req_msk = '0;
      hit     = -1;
      for (int j = 0; j < 2*N; j++) begin
         req_msk[j] = req_dbl[j] && (j >= base);
      end
      for (int j = 2*N-1; j >= 0; j--) begin
         if (req_msk[j]) hit = j;
      end
   end

   assign grant_idx = (hit < 0)  ? '0 :
                      (hit >= N) ? SEL_W'(hit - N) : SEL_W'(hit);
   assign grant     = (hit < 0)  ? '0 : (N'(1) << grant_idx);

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with a single registered output stage.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   mode              - MODE_FIXED or MODE_RR arbitration
//   in_valid/in_ready - per-channel handshake (in_ready is one-hot or zero)
//   in_data           - packed payloads, channel i at [i*W +: W]
//   out_valid/out_ready, out_data, out_sel - registered output word and source index
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int W     = 4,
   parameter int SEL_W = sel_width(N_IN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [N_IN-1:0]   in_valid,
   input  logic [N_IN*W-1:0] in_data,
   output logic [N_IN-1:0]   in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_sel,
   input  logic              out_ready
);

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q, out_data_d;
   logic [SEL_W-1:0] out_sel_q, out_sel_d;

   logic [N_IN-1:0]  grant;
   logic [SEL_W-1:0] grant_idx;
   logic [W-1:0]     sel_data;
   logic             load_ok;
   logic             accept;

   rr_arbiter #(
      .N     (N_IN),
      .SEL_W (SEL_W)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .mode      (mode),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // The stage may take a new word when empty or when its word leaves this cycle.
   assign load_ok  = ~out_valid_q | out_ready;
   assign in_ready = grant & {N_IN{load_ok}};
   assign accept   = |in_ready;
   assign sel_data = in_data[int'(grant_idx)*W +: W];

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_sel_d   = grant_idx;
         if (mode == MODE_RR) begin
            // Explicit wrap: N_IN need not be a power of two.
            ptr_d = (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: N_IN=4, W=4
   logic        a_rst, a_mode, a_ordy, a_ov;
   logic [3:0]  a_iv, a_ir, a_od;
   logic [15:0] a_id;
   logic [1:0]  a_os;
   int          ma_ptr, ma_os;
   logic        ma_ov;
   logic [7:0]  ma_od;

   // Instance B: N_IN=3, W=4
   logic        b_rst, b_mode, b_ordy, b_ov;
   logic [2:0]  b_iv, b_ir;
   logic [11:0] b_id;
   logic [3:0]  b_od;
   logic [1:0]  b_os;
   int          mb_ptr, mb_os;
   logic        mb_ov;
   logic [7:0]  mb_od;

   // Instance C: N_IN=5, W=8
   logic        c_rst, c_mode, c_ordy, c_ov;
   logic [4:0]  c_iv, c_ir;
   logic [39:0] c_id;
   logic [7:0]  c_od;
   logic [2:0]  c_os;
   int          mc_ptr, mc_os;
   logic        mc_ov;
   logic [7:0]  mc_od;
   int          c_seq  [5];
   int          c_wait [5];
   logic [7:0]  sb_q [$];
   int          last_g, cg;
   logic [15:0] cir;
   logic        c_drain;

   stream_mux_rr #(.N_IN(4), .W(4)) u_a (
      .clk(clk), .rst(a_rst), .mode(a_mode), .in_valid(a_iv), .in_data(a_id),
      .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od), .out_sel(a_os), .out_ready(a_ordy));

   stream_mux_rr #(.N_IN(3), .W(4)) u_b (
      .clk(clk), .rst(b_rst), .mode(b_mode), .in_valid(b_iv), .in_data(b_id),
      .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od), .out_sel(b_os), .out_ready(b_ordy));

   stream_mux_rr #(.N_IN(5), .W(8)) u_c (
      .clk(clk), .rst(c_rst), .mode(c_mode), .in_valid(c_iv), .in_data(c_id),
      .in_ready(c_ir), .out_valid(c_ov), .out_data(c_od), .out_sel(c_os), .out_ready(c_ordy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Winner by the arbitration rules: scan channels from the start point, wrapping.
   function automatic int exp_grant(input int n, input logic [15:0] iv, input int ptr,
                                    input logic md);
      for (int k = 0; k < n; k++) begin
         int i;
         i = md ? (ptr + k) % n : k;
         if (iv[i]) return i;
      end
      return -1;
   endfunction

   // One clock of the behavioural model; g returns the accepted channel or -1.
   task automatic model_step(input int n, input int w, input logic md, input logic [15:0] iv,
                             input logic [127:0] id, input logic ordy,
                             inout int ptr, inout logic ov, inout logic [7:0] od, inout int os,
                             output logic [15:0] ir, output int g);
      int  win;
      logic acc;
      win = exp_grant(n, iv, ptr, md);
      acc = (win >= 0) && (!ov || ordy);
      ir  = '0;
      g   = -1;
      if (acc) begin
         ir[win] = 1'b1;
         g       = win;
         od      = 8'((id >> (win * w)) & ((128'(1) << w) - 128'(1)));
         os      = win;
         ov      = 1'b1;
         if (md) ptr = (win + 1) % n;
      end else if (ordy) begin
         ov = 1'b0;
      end
   endtask

   task automatic step_a(input logic r, input logic md, input logic [3:0] iv,
                         input logic [15:0] id, input logic ordy);
      logic [15:0] ir;
      int g;
      @(negedge clk);
      a_rst = r; a_mode = md; a_iv = iv; a_id = id; a_ordy = ordy;
      #1;
      if (r) begin ma_ptr = 0; ma_ov = 1'b0; ma_od = '0; ma_os = 0; end
      chk("a_out_valid", a_ov, ma_ov);
      chk("a_out_data", a_od, ma_od);
      chk("a_out_sel", a_os, ma_os);
      if (!r) begin
         model_step(4, 4, md, 16'(iv), 128'(id), ordy, ma_ptr, ma_ov, ma_od, ma_os, ir, g);
         chk("a_in_ready", a_ir, ir[3:0]);
      end
   endtask

   task automatic step_b(input logic r, input logic md, input logic [2:0] iv,
                         input logic [11:0] id, input logic ordy);
      logic [15:0] ir;
      int g;
      @(negedge clk);
      b_rst = r; b_mode = md; b_iv = iv; b_id = id; b_ordy = ordy;
      #1;
      if (r) begin mb_ptr = 0; mb_ov = 1'b0; mb_od = '0; mb_os = 0; end
      chk("b_out_valid", b_ov, mb_ov);
      chk("b_out_data", b_od, mb_od);
      chk("b_out_sel", b_os, mb_os);
      if (!r) begin
         model_step(3, 4, md, 16'(iv), 128'(id), ordy, mb_ptr, mb_ov, mb_od, mb_os, ir, g);
         chk("b_in_ready", b_ir, ir[2:0]);
      end
   endtask

   initial begin
      a_rst = 1'b1; a_mode = 1'b1; a_iv = '0; a_id = '0; a_ordy = 1'b1;
      b_rst = 1'b1; b_mode = 1'b1; b_iv = '0; b_id = '0; b_ordy = 1'b1;
      c_rst = 1'b1; c_mode = 1'b1; c_iv = '0; c_id = '0; c_ordy = 1'b1;
      ma_ptr = 0; ma_ov = 1'b0; ma_od = '0; ma_os = 0;
      mb_ptr = 0; mb_ov = 1'b0; mb_od = '0; mb_os = 0;
      mc_ptr = 0; mc_ov = 1'b0; mc_od = '0; mc_os = 0;
      for (int i = 0; i < 5; i++) begin c_seq[i] = 0; c_wait[i] = 0; end
      last_g = -1;

      // Reset held with all channels requesting, then round-robin rotation.
      for (int k = 0; k < 3; k++) step_a(1'b1, 1'b1, 4'hF, 16'h4321, 1'b1);
      for (int k = 0; k < 9; k++) begin
         step_a(1'b0, 1'b1, 4'hF, 16'h4321, 1'b1);
         if (k >= 1) begin
            chk("a_rr_seq", a_os, (k - 1) % 4);
            chk("a_rr_data", a_od, ((k - 1) % 4) + 1);
         end
      end

      // Fixed priority: channel 1 always beats channel 3.
      for (int k = 0; k < 6; k++) begin
         step_a(1'b0, 1'b0, 4'b1010, 16'hA050, 1'b1);
         chk("a_fixed_ready", a_ir, 4'b0010);
         if (k >= 1) begin
            chk("a_fixed_sel", a_os, 1);
            chk("a_fixed_data", a_od, 4'h5);
         end
      end

      // Backpressure for three cycles, then drain and reload in one edge.
      for (int k = 0; k < 3; k++) begin
         step_a(1'b0, 1'b1, 4'hF, 16'h4321, 1'b0);
         chk("a_bp_ready", a_ir, 4'b0000);
         chk("a_bp_data", a_od, 4'h5);
         chk("a_bp_valid", a_ov, 1'b1);
      end
      step_a(1'b0, 1'b1, 4'hF, 16'h4321, 1'b1);
      chk("a_bp_release_ready", a_ir, 4'b0010);
      step_a(1'b0, 1'b1, 4'hF, 16'h4321, 1'b1);
      chk("a_bp_reload_sel", a_os, 1);
      chk("a_bp_reload_data", a_od, 4'h2);
      chk("a_bp_reload_valid", a_ov, 1'b1);

      // Asynchronous reset pulse right after out_valid rises under backpressure.
      step_a(1'b0, 1'b1, 4'b0000, 16'h4321, 1'b1);
      step_a(1'b0, 1'b1, 4'b0001, 16'h0007, 1'b0);
      @(negedge clk);
      #1;
      chk("a_pre_rst_valid", a_ov, 1'b1);
      chk("a_pre_rst_data", a_od, 4'h7);
      a_iv  = '0;
      a_rst = 1'b1;
      #1;
      chk("a_async_rst_valid", a_ov, 1'b0);
      chk("a_async_rst_data", a_od, 4'h0);
      chk("a_async_rst_sel", a_os, 0);
      #1;
      a_rst = 1'b0;
      ma_ptr = 0; ma_ov = 1'b0; ma_od = '0; ma_os = 0;
      step_a(1'b0, 1'b1, 4'hF, 16'h4321, 1'b1);
      step_a(1'b0, 1'b1, 4'hF, 16'h4321, 1'b1);
      chk("a_ptr_after_rst", a_os, 0);

      // N_IN=3: lone channel 2 grant wraps the pointer to 0.
      step_b(1'b1, 1'b1, 3'b000, 12'h321, 1'b1);
      step_b(1'b0, 1'b1, 3'b100, 12'h321, 1'b1);
      for (int j = 1; j <= 4; j++) begin
         step_b(1'b0, 1'b1, 3'b111, 12'h321, 1'b1);
         chk("b_wrap_seq", b_os, (j == 1) ? 2 : (j - 2));
      end

      // Randomised traffic on N_IN=5, W=8.
      @(negedge clk);
      c_rst = 1'b0;
      for (int cyc = 0; cyc < 700; cyc++) begin
         c_drain = (cyc >= 680);
         @(negedge clk);
         if (last_g >= 0) begin
            c_iv[last_g] = 1'b0;
            c_seq[last_g]++;
         end
         for (int i = 0; i < 5; i++) begin
            c_id[i*8 +: 8] = {3'(i), 5'(c_seq[i])};
            if (!c_drain && !c_iv[i] && $urandom_range(1, 0) == 1) c_iv[i] = 1'b1;
         end
         if (!c_drain && $urandom_range(15, 0) == 0) c_mode = ~c_mode;
         c_ordy = c_drain ? 1'b1 : ($urandom_range(3, 0) != 0);
         #1;
         chk("c_out_valid", c_ov, mc_ov);
         chk("c_out_data", c_od, mc_od);
         chk("c_out_sel", c_os, mc_os);
         chk("c_onehot0", $onehot0(c_ir), 1);
         if (mc_ov && c_ordy) begin
            chk("c_sb_count", sb_q.size(), 1);
            if (sb_q.size() > 0) chk("c_sb_word", c_od, sb_q.pop_front());
         end
         model_step(5, 8, c_mode, 16'(c_iv), 128'(c_id), c_ordy,
                    mc_ptr, mc_ov, mc_od, mc_os, cir, cg);
         chk("c_in_ready", c_ir, cir[4:0]);
         if (cg >= 0) sb_q.push_back(c_id[cg*8 +: 8]);
         if (!c_mode) begin
            for (int i = 0; i < 5; i++) c_wait[i] = 0;
         end else if (cg >= 0) begin
            for (int i = 0; i < 5; i++) begin
               if (i == cg) c_wait[i] = 0;
               else if (c_iv[i]) begin
                  c_wait[i]++;
                  chk("c_rr_bound", c_wait[i] <= 4, 1);
               end else c_wait[i] = 0;
            end
         end
         last_g = cg;
      end
      chk("c_sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
